// File: rtl/mem_port_arbiter.sv
// Shares one memory request port between instruction fetch (IF) and data memory (DM).
// Responses come back in order and are routed to their owner through an owner-ID FIFO.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               if_req_valid,
  output logic                               if_req_ready,
  input  logic [ADDR_W-1:0]                  if_req_addr,
  output logic                               if_rsp_valid,
  output logic [DATA_W-1:0]                  if_rsp_data,
  input  logic                               dm_req_valid,
  output logic                               dm_req_ready,
  input  logic [ADDR_W-1:0]                  dm_req_addr,
  input  logic [DATA_W-1:0]                  dm_req_wdata,
  input  logic [DATA_W/8-1:0]                dm_req_be,
  output logic                               dm_rsp_valid,
  output logic [DATA_W-1:0]                  dm_rsp_data,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [ADDR_W-1:0]                  mem_req_addr,
  output logic [DATA_W-1:0]                  mem_req_wdata,
  output logic [DATA_W/8-1:0]                mem_req_be,
  input  logic                               mem_rsp_valid,
  input  logic [DATA_W-1:0]                  mem_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               rsp_error
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_IF, LOCK_DM} lock_t;

  lock_t            lock_q, lock_d;
  logic [SC_W-1:0]  starve_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             owner_q [MAX_OUTSTANDING];

  logic sel_dm, sel_valid, full, empty, grant_ok;
  logic push, pop, if_hs, dm_hs;

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  always_comb begin
    sel_dm = 1'b0;
    unique case (lock_q)
      LOCK_IF: sel_dm = 1'b0;
      LOCK_DM: sel_dm = 1'b1;
      default: begin
        if ((starve_q == SC_W'(STARVE_LIMIT)) && if_req_valid) sel_dm = 1'b0;
        else                                                   sel_dm = dm_req_valid;
      end
    endcase
  end

  // Request-side outputs are forced to their idle values while reset is held.
  assign sel_valid     = sel_dm ? dm_req_valid : if_req_valid;
  assign mem_req_valid = reset && sel_valid && !full;
  assign grant_ok      = reset && mem_req_ready && !full;
  assign if_req_ready  = grant_ok && !sel_dm;
  assign dm_req_ready  = grant_ok && sel_dm;

  assign push  = mem_req_valid && mem_req_ready;
  assign if_hs = push && !sel_dm;
  assign dm_hs = push && sel_dm;
  assign pop   = reset && mem_rsp_valid && !empty;

  always_comb begin
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_be    = '0;
    if (mem_req_valid) begin
      if (sel_dm) begin
        mem_req_addr  = dm_req_addr;
        mem_req_wdata = dm_req_wdata;
        mem_req_be    = dm_req_be;
      end else begin
        mem_req_addr  = if_req_addr;
      end
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (mem_req_valid && !mem_req_ready) lock_d = sel_dm ? LOCK_DM : LOCK_IF;
    else                                 lock_d = LOCK_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lock_q <= LOCK_NONE;
    else        lock_q <= lock_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (!if_req_valid || if_hs) begin
      starve_q <= '0;
    end else if (dm_hs && (starve_q != SC_W'(STARVE_LIMIT))) begin
      starve_q <= starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (mem_rsp_valid && empty) rsp_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) owner_q[wr_ptr_q] <= sel_dm;
  end

  assign if_rsp_valid = pop && !owner_q[rd_ptr_q];
  assign dm_rsp_valid = pop && owner_q[rd_ptr_q];
  assign if_rsp_data  = mem_rsp_data;
  assign dm_rsp_data  = mem_rsp_data;
  assign outstanding  = count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, lock, starvation, full FIFO, error and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        dm_req_valid, dm_req_ready, dm_rsp_valid;
  logic [31:0] dm_req_addr, dm_req_wdata, dm_rsp_data;
  logic [3:0]  dm_req_be;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_be;
  logic [2:0]  outstanding;
  logic        rsp_error;

  int checks = 0;
  int errors = 0;
  logic [9:0] pat;
  logic [3:0] own;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_be(dm_req_be),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .outstanding(outstanding), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    dm_req_valid = 1'b1; dm_req_addr = 32'h200; dm_req_wdata = 32'h1234; dm_req_be = 4'hF;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0;
    #3;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid got %h exp 0", mem_req_valid); end
    checks++; if (if_req_ready !== 1'b0) begin errors++; $display("FAIL rst_if_req_ready got %h exp 0", if_req_ready); end
    checks++; if (dm_req_ready !== 1'b0) begin errors++; $display("FAIL rst_dm_req_ready got %h exp 0", dm_req_ready); end
    checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_req_addr got %h exp 0", mem_req_addr); end
    checks++; if (mem_req_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_req_wdata got %h exp 0", mem_req_wdata); end
    checks++; if (mem_req_be !== 4'h0) begin errors++; $display("FAIL rst_mem_req_be got %h exp 0", mem_req_be); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL rst_rsp_error got %h exp 0", rsp_error); end
    checks++; if (if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b%b exp 00", if_rsp_valid, dm_rsp_valid); end
    if_req_valid = 1'b0; dm_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick();
  endtask

  task automatic test_single_if_read;
    if_req_valid = 1'b1; if_req_addr = 32'h100; mem_req_ready = 1'b1;
    #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL if_read_valid got %h exp 1", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h100) begin errors++; $display("FAIL if_read_addr got %h exp 100", mem_req_addr); end
    checks++; if (mem_req_be !== 4'h0) begin errors++; $display("FAIL if_read_be got %h exp 0", mem_req_be); end
    checks++; if (if_req_ready !== 1'b1 || dm_req_ready !== 1'b0) begin errors++; $display("FAIL if_read_ready got %b%b exp 10", if_req_ready, dm_req_ready); end
    tick();
    if_req_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL if_read_out1 got %0d exp 1", outstanding); end
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    #1;
    checks++; if (if_rsp_valid !== 1'b1 || dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL if_read_rsp_valid got %b%b exp 10", if_rsp_valid, dm_rsp_valid); end
    checks++; if (if_rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL if_read_rsp_data got %h exp deadbeef", if_rsp_data); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL if_read_out0 got %0d exp 0", outstanding); end
  endtask

  task automatic test_contention;
    if_req_valid = 1'b1; if_req_addr = 32'h104;
    dm_req_valid = 1'b1; dm_req_addr = 32'h200; dm_req_wdata = 32'h12345678; dm_req_be = 4'hF;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (dm_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin errors++; $display("FAIL cont_first_ready got dm%b if%b exp dm1 if0", dm_req_ready, if_req_ready); end
    checks++; if (mem_req_addr !== 32'h200 || mem_req_be !== 4'hF || mem_req_wdata !== 32'h12345678) begin errors++; $display("FAIL cont_first_fields got %h/%h/%h exp 200/f/12345678", mem_req_addr, mem_req_be, mem_req_wdata); end
    tick();
    dm_req_valid = 1'b0;
    #1;
    checks++; if (if_req_ready !== 1'b1 || mem_req_addr !== 32'h104) begin errors++; $display("FAIL cont_second got rdy%b addr %h exp rdy1 addr 104", if_req_ready, mem_req_addr); end
    checks++; if (mem_req_be !== 4'h0 || mem_req_wdata !== 32'h0) begin errors++; $display("FAIL cont_second_be got %h/%h exp 0/0", mem_req_be, mem_req_wdata); end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL cont_out got %0d exp 2", outstanding); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA1;
    #1;
    checks++; if (dm_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0 || dm_rsp_data !== 32'hA1) begin errors++; $display("FAIL cont_rsp_dm got dm%b if%b %h exp dm1 if0 a1", dm_rsp_valid, if_rsp_valid, dm_rsp_data); end
    tick();
    mem_rsp_data = 32'hB2;
    #1;
    checks++; if (if_rsp_valid !== 1'b1 || dm_rsp_valid !== 1'b0 || if_rsp_data !== 32'hB2) begin errors++; $display("FAIL cont_rsp_if got if%b dm%b %h exp if1 dm0 b2", if_rsp_valid, dm_rsp_valid, if_rsp_data); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL cont_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_starvation;
    pat = 10'b0111101111;
    if_req_valid = 1'b1; if_req_addr = 32'h300;
    dm_req_valid = 1'b1; dm_req_addr = 32'h400; dm_req_be = 4'h0; dm_req_wdata = 32'h0;
    mem_req_ready = 1'b1; mem_rsp_data = 32'h5;
    for (int g = 0; g < 10; g++) begin
      mem_rsp_valid = (g != 0);
      #1;
      checks++; if (mem_req_addr !== (pat[g] ? 32'h400 : 32'h300) || dm_req_ready !== pat[g]) begin errors++; $display("FAIL starve_grant_%0d got addr %h dm_rdy %b exp dm %b", g, mem_req_addr, dm_req_ready, pat[g]); end
      if (g != 0) begin
        checks++; if (dm_rsp_valid !== pat[g-1] || if_rsp_valid !== !pat[g-1]) begin errors++; $display("FAIL starve_rsp_%0d got dm%b if%b exp dm %b", g, dm_rsp_valid, if_rsp_valid, pat[g-1]); end
      end
      tick();
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    #1;
    checks++; if (if_rsp_valid !== 1'b1) begin errors++; $display("FAIL starve_last_rsp got %b exp 1", if_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL starve_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_backpressure_lock;
    dm_req_valid = 1'b1; dm_req_addr = 32'h500; dm_req_be = 4'h3; dm_req_wdata = 32'hCAFE;
    if_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h500 || dm_req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall0 got v%b %h rdy%b exp v1 500 rdy0", mem_req_valid, mem_req_addr, dm_req_ready); end
    tick();
    if_req_valid = 1'b1; if_req_addr = 32'h600;
    #1;
    checks++; if (mem_req_addr !== 32'h500 || mem_req_be !== 4'h3 || if_req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall1 got %h be %h ifrdy %b exp 500 3 0", mem_req_addr, mem_req_be, if_req_ready); end
    tick();
    #1;
    checks++; if (mem_req_addr !== 32'h500 || mem_req_be !== 4'h3) begin errors++; $display("FAIL bp_stall2 got %h be %h exp 500 3", mem_req_addr, mem_req_be); end
    tick();
    mem_req_ready = 1'b1;
    #1;
    checks++; if (dm_req_ready !== 1'b1 || mem_req_addr !== 32'h500) begin errors++; $display("FAIL bp_accept_dm got rdy%b %h exp 1 500", dm_req_ready, mem_req_addr); end
    tick();
    dm_req_valid = 1'b0;
    #1;
    checks++; if (if_req_ready !== 1'b1 || mem_req_addr !== 32'h600) begin errors++; $display("FAIL bp_accept_if got rdy%b %h exp 1 600", if_req_ready, mem_req_addr); end
    tick();
    if_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL bp_out got %0d exp 2", outstanding); end
    if_req_valid = 1'b1; if_req_addr = 32'h700;
    #1;
    checks++; if (mem_req_addr !== 32'h700) begin errors++; $display("FAIL lock_if0 got %h exp 700", mem_req_addr); end
    tick();
    dm_req_valid = 1'b1; dm_req_addr = 32'h800; dm_req_be = 4'hF; dm_req_wdata = 32'h1;
    #1;
    checks++; if (mem_req_addr !== 32'h700 || mem_req_be !== 4'h0) begin errors++; $display("FAIL lock_if_hold got %h be %h exp 700 0", mem_req_addr, mem_req_be); end
    tick();
    mem_req_ready = 1'b1;
    #1;
    checks++; if (if_req_ready !== 1'b1 || dm_req_ready !== 1'b0 || mem_req_addr !== 32'h700) begin errors++; $display("FAIL lock_if_accept got if%b dm%b %h exp 1 0 700", if_req_ready, dm_req_ready, mem_req_addr); end
    tick();
    if_req_valid = 1'b0;
    #1;
    checks++; if (dm_req_ready !== 1'b1 || mem_req_addr !== 32'h800) begin errors++; $display("FAIL lock_dm_after got rdy%b %h exp 1 800", dm_req_ready, mem_req_addr); end
    tick();
    dm_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL lock_out got %0d exp 4", outstanding); end
    own = 4'b1001;
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dm_rsp_valid !== own[i] || if_rsp_valid !== !own[i]) begin errors++; $display("FAIL lock_rsp_%0d got dm%b if%b exp dm %b", i, dm_rsp_valid, if_rsp_valid, own[i]); end
      tick();
    end
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL lock_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_full;
    if_req_valid = 1'b1; if_req_addr = 32'h900; dm_req_valid = 1'b0; mem_req_ready = 1'b1;
    repeat (4) tick();
    dm_req_valid = 1'b1; dm_req_addr = 32'hA00; dm_req_be = 4'hF; dm_req_wdata = 32'h2;
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_out got %0d exp 4", outstanding); end
    checks++; if (if_req_ready !== 1'b0 || dm_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_block got if%b dm%b v%b exp 000", if_req_ready, dm_req_ready, mem_req_valid); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || dm_req_ready !== 1'b0) begin errors++; $display("FAIL full_pop_block got v%b rdy%b exp 0 0", mem_req_valid, dm_req_ready); end
    checks++; if (if_rsp_valid !== 1'b1) begin errors++; $display("FAIL full_pop_rsp got %b exp 1", if_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3 || dm_req_ready !== 1'b1 || mem_req_addr !== 32'hA00) begin errors++; $display("FAIL full_next_grant got %0d rdy%b %h exp 3 1 a00", outstanding, dm_req_ready, mem_req_addr); end
    tick();
    if_req_valid = 1'b0; dm_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill got %0d exp 4", outstanding); end
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 3) begin
        checks++; if (dm_rsp_valid !== 1'b1) begin errors++; $display("FAIL full_last_rsp got %b exp 1", dm_rsp_valid); end
      end
      tick();
    end
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_error_reset;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77;
    #1;
    checks++; if (if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL err_no_rsp got %b%b exp 00", if_rsp_valid, dm_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (rsp_error !== 1'b1 || outstanding !== 3'd0) begin errors++; $display("FAIL err_flag got %b out %0d exp 1 0", rsp_error, outstanding); end
    dm_req_valid = 1'b1; dm_req_addr = 32'hB00; dm_req_be = 4'hF; dm_req_wdata = 32'h99; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || outstanding !== 3'd1) begin errors++; $display("FAIL mid_pre got v%b out %0d exp 1 1", mem_req_valid, outstanding); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || dm_req_ready !== 1'b0 || if_req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_hs got v%b dm%b if%b exp 000", mem_req_valid, dm_req_ready, if_req_ready); end
    checks++; if (mem_req_addr !== 32'h0 || mem_req_be !== 4'h0 || mem_req_wdata !== 32'h0) begin errors++; $display("FAIL mid_rst_fields got %h/%h/%h exp 0/0/0", mem_req_addr, mem_req_be, mem_req_wdata); end
    checks++; if (outstanding !== 3'd0 || rsp_error !== 1'b0) begin errors++; $display("FAIL mid_rst_state got out %0d err %b exp 0 0", outstanding, rsp_error); end
    dm_req_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    mem_rsp_valid = 1'b1;
    #1;
    checks++; if (if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_rsp got %b%b exp 00", if_rsp_valid, dm_rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    checks++; if (rsp_error !== 1'b1) begin errors++; $display("FAIL post_rst_err got %b exp 1", rsp_error); end
  endtask

  initial begin
    test_reset();
    test_single_if_read();
    test_contention();
    test_starvation();
    test_backpressure_lock();
    test_full();
    test_error_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
